// File: rtl/mimc_pkg.sv
// Shared constants, FSM encodings and the single-step modular reduction
// used by the MiMC7 multiHash controller.
package mimc_pkg;

   localparam int MIMC_W = 254;
   localparam int W_EXT  = MIMC_W + 2;

   typedef logic [W_EXT-1:0] ext_t;

   localparam ext_t P_MOD_EXT = 256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
   localparam logic [MIMC_W-1:0] P_MOD_BN254 = P_MOD_EXT[MIMC_W-1:0];

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] LOAD = 3'd1;
   localparam logic [2:0] RUN  = 3'd2;
   localparam logic [2:0] ACC  = 3'd3;
   localparam logic [2:0] OUT  = 3'd4;

   // One conditional subtraction; callers chain it when the operand may exceed 2p.
   function automatic ext_t mod_reduce_once(input ext_t v, input ext_t p);
      return (v >= p) ? v - p : v;
   endfunction

endpackage

// File: rtl/mimc_mod_add3.sv
// Combinational (a + b + c) mod p for operands already in [0, p).
module mimc_mod_add3
   import mimc_pkg::*;
#(
   parameter int                N_BITS = MIMC_W,
   parameter logic [N_BITS-1:0] P_MOD  = P_MOD_BN254
) (
   input  logic [N_BITS-1:0] a,
   input  logic [N_BITS-1:0] b,
   input  logic [N_BITS-1:0] c,
   output logic [N_BITS-1:0] sum
);

   localparam ext_t P_EXT = ext_t'(P_MOD);

   ext_t s_raw;
   ext_t s_one;
   ext_t s_two;

   // Sum of three residues is below 3p, so two conditional subtractions suffice.
   always_comb begin
      s_raw = ext_t'(a) + ext_t'(b) + ext_t'(c);
      s_one = mod_reduce_once(s_raw, P_EXT);
      s_two = mod_reduce_once(s_one, P_EXT);
      sum   = N_BITS'(s_two);
   end

endmodule

// File: rtl/mimc_hash_ctrl.sv
// MiMC7 multiHash sequencer: r(i+1) = r(i) + x(i) + E(x(i), r(i)) mod p,
// one external cipher call per streamed element, final r on the output port.
module mimc_hash_ctrl
   import mimc_pkg::*;
#(
   parameter int                N_BITS         = MIMC_W,
   parameter logic [N_BITS-1:0] P_MOD          = P_MOD_BN254,
   parameter int                TIMEOUT_CYCLES = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_BITS-1:0] in_data,
   input  logic              in_last,
   input  logic [N_BITS-1:0] in_key,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N_BITS-1:0] out_hash,
   output logic              err,
   output logic              cipher_rst,
   output logic              cipher_en,
   output logic [N_BITS-1:0] cipher_in,
   output logic [N_BITS-1:0] cipher_key,
   input  logic [N_BITS-1:0] cipher_out,
   input  logic              cipher_done
);

   localparam ext_t P_EXT = ext_t'(P_MOD);
   localparam int   CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [2:0]        state;
   logic              first_beat;
   logic              last_q;
   logic [N_BITS-1:0] r;
   logic [N_BITS-1:0] x;
   logic [N_BITS-1:0] c;
   logic [CNT_W-1:0]  cnt;
   logic [N_BITS-1:0] data_red;
   logic [N_BITS-1:0] key_red;
   logic [N_BITS-1:0] s_acc;

   // Inputs may lie in [p, 2^254); since 2^254 < 2p one subtraction lands in range.
   assign data_red = N_BITS'(mod_reduce_once(ext_t'(in_data), P_EXT));
   assign key_red  = N_BITS'(mod_reduce_once(ext_t'(in_key), P_EXT));

   mimc_mod_add3 #(
      .N_BITS (N_BITS),
      .P_MOD  (P_MOD)
   ) u_add3 (
      .a   (r),
      .b   (x),
      .c   (c),
      .sum (s_acc)
   );

   // The reset term keeps in_ready low while rst is held, even though state reads IDLE.
   assign in_ready   = rst && (state == IDLE);
   assign out_valid  = (state == OUT);
   assign cipher_rst = (state != RUN);
   assign cipher_en  = (state == RUN);
   assign cipher_in  = x;
   assign cipher_key = r;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         first_beat <= 1'b1;
         last_q     <= 1'b0;
         r          <= '0;
         x          <= '0;
         c          <= '0;
         cnt        <= '0;
         out_hash   <= '0;
         err        <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every branch sees pre-edge values.
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  x          <= data_red;
                  if (first_beat) r <= key_red;
                  last_q     <= in_last;
                  first_beat <= 1'b0;
                  state      <= LOAD;
               end
            end
            LOAD: begin
               cnt   <= '0;
               state <= RUN;
            end
            RUN: begin
               if (cipher_done) begin
                  c     <= cipher_out;
                  state <= ACC;
               end else if (cnt == CNT_LAST) begin
                  // Abandon the message; later beats start a fresh chain.
                  err        <= 1'b1;
                  first_beat <= 1'b1;
                  state      <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ACC: begin
               r <= s_acc;
               if (last_q) begin
                  out_hash   <= s_acc;
                  first_beat <= 1'b1;
                  state      <= OUT;
               end else begin
                  state <= IDLE;
               end
            end
            OUT: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mimc_hash_ctrl.sv
// Scoreboard bench for mimc_hash_ctrl with a behavioural 5-cycle cipher stub.
module tb_mimc_hash_ctrl;

   localparam logic [255:0] P256 = 256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
   localparam int STUB_LAT = 5;
   localparam int TO_CYC   = 16;
   localparam int BOUND    = 200;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [253:0] in_data = '0;
   logic         in_last = 1'b0;
   logic [253:0] in_key = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [253:0] out_hash;
   logic         err;
   logic         cipher_rst;
   logic         cipher_en;
   logic [253:0] cipher_in;
   logic [253:0] cipher_key;
   logic [253:0] cipher_out = '0;
   logic         cipher_done = 1'b0;

   logic [253:0] p;
   int           checks = 0;
   int           errors = 0;
   int           stub_mode = 0;   // 0 normal, 1 force p-1, 2 never done
   int           scnt = 0;

   logic [253:0] exp_hash_q[$];
   logic [253:0] exp_in_q[$];
   logic [253:0] exp_key_q[$];

   always #5 clk = ~clk;

   mimc_hash_ctrl #(.TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .in_key      (in_key),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_hash    (out_hash),
      .err         (err),
      .cipher_rst  (cipher_rst),
      .cipher_en   (cipher_en),
      .cipher_in   (cipher_in),
      .cipher_key  (cipher_key),
      .cipher_out  (cipher_out),
      .cipher_done (cipher_done)
   );

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   function automatic logic [253:0] stub_result(input logic [253:0] a, input logic [253:0] k);
      logic [255:0] t;
      t = {2'b00, a} + {2'b00, k} + 256'd1;
      if (t >= {2'b00, p}) t = t - {2'b00, p};
      return t[253:0];
   endfunction

   // Cipher stub: done rises STUB_LAT cycles after enable, cleared by cipher_rst.
   always @(posedge clk) begin
      if (cipher_rst) begin
         scnt        <= 0;
         cipher_done <= 1'b0;
      end else if (cipher_en && !cipher_done) begin
         scnt <= scnt + 1;
         if (scnt == STUB_LAT - 1 && stub_mode != 2) begin
            cipher_done <= 1'b1;
            cipher_out  <= (stub_mode == 1) ? p - 254'd1 : stub_result(cipher_in, cipher_key);
         end
      end
   end

   // Monitor: cipher calls, output handshakes, and output stability during stalls.
   logic         en_prev = 1'b0;
   logic         v_prev = 1'b0;
   logic         acc_prev = 1'b0;
   logic [253:0] h_prev = '0;
   always @(negedge clk) begin
      if (cipher_en && !en_prev) begin
         if (exp_in_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL call_unexpected in=%h key=%h", cipher_in, cipher_key);
         end else begin
            check("cipher_in", {2'b00, cipher_in}, {2'b00, exp_in_q.pop_front()});
            check("cipher_key", {2'b00, cipher_key}, {2'b00, exp_key_q.pop_front()});
         end
      end
      if (v_prev && !acc_prev) begin
         check("stall_valid", {255'd0, out_valid}, 256'd1);
         check("stall_hash", {2'b00, out_hash}, {2'b00, h_prev});
      end
      if (rst && out_valid && out_ready) begin
         if (exp_hash_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL out_unexpected got=%h", out_hash);
         end else begin
            check("out_hash", {2'b00, out_hash}, {2'b00, exp_hash_q.pop_front()});
         end
      end
      en_prev  = cipher_en;
      v_prev   = rst && out_valid;
      acc_prev = out_valid && out_ready;
      h_prev   = out_hash;
   end

   task automatic send(input logic [253:0] key, input logic [253:0] data, input logic last);
      int n;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_key   = key;
      in_data  = data;
      in_last  = last;
      n = 0;
      while (!in_ready && n < BOUND) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= BOUND) begin
         checks++; errors++;
         $display("FAIL in_ready_timeout got=0 want=1");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic push_call(input logic [253:0] a, input logic [253:0] k);
      exp_in_q.push_back(a);
      exp_key_q.push_back(k);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_hash_q.size() != 0 && n < BOUND) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_left", 256'(exp_hash_q.size()), 256'd0);
   endtask

   initial begin
      int lat;
      int n;
      p = P256[253:0];

      #12;
      check("rst_in_ready", {255'd0, in_ready}, 256'd0);
      check("rst_out_valid", {255'd0, out_valid}, 256'd0);
      check("rst_cipher_rst", {255'd0, cipher_rst}, 256'd1);
      check("rst_cipher_en", {255'd0, cipher_en}, 256'd0);
      check("rst_err", {255'd0, err}, 256'd0);
      check("rst_out_hash", {2'b00, out_hash}, 256'd0);
      @(negedge clk); rst = 1'b1;

      // Single element, key 0: E=6, hash 11, 8 cycles after the accept edge.
      push_call(254'd5, 254'd0);
      exp_hash_q.push_back(254'd11);
      send(254'd0, 254'd5, 1'b1);
      lat = 0;
      while (!out_valid && lat < BOUND) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 256'(lat), 256'(1 + 1 + STUB_LAT + 1));
      drain();

      // Two elements; the key on the second beat must be ignored.
      push_call(254'd1, 254'd3);
      push_call(254'd2, 254'd9);
      exp_hash_q.push_back(254'd23);
      send(254'd3, 254'd1, 1'b0);
      send(254'd100, 254'd2, 1'b1);
      drain();

      // Wrap-around: (p-1)*3 reduces to p-3.
      stub_mode = 1;
      push_call(p - 254'd1, p - 254'd1);
      exp_hash_q.push_back(p - 254'd3);
      send(p - 254'd1, p - 254'd1, 1'b1);
      drain();
      stub_mode = 0;

      // Non-canonical input p+4 and key p+2 reduce to 4 and 2: E=7, hash 13.
      push_call(254'd4, 254'd2);
      exp_hash_q.push_back(254'd13);
      send(p + 254'd2, p + 254'd4, 1'b1);
      drain();

      // Output back-pressure for 10 cycles: key 7, x 10, E=18, hash 35.
      out_ready = 1'b0;
      push_call(254'd10, 254'd7);
      exp_hash_q.push_back(254'd35);
      send(254'd7, 254'd10, 1'b1);
      n = 0;
      while (!out_valid && n < BOUND) begin
         @(posedge clk); #1;
         n++;
      end
      check("stall_reached", {255'd0, out_valid}, 256'd1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("stall_in_ready", {255'd0, in_ready}, 256'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("stall_released", {255'd0, out_valid}, 256'd0);
      check("stall_popped", 256'(exp_hash_q.size()), 256'd0);

      // Cipher never answers: err after exactly TO_CYC enabled cycles.
      stub_mode = 2;
      push_call(254'd1, 254'd0);
      send(254'd0, 254'd1, 1'b1);
      n = 0;
      lat = 0;
      while (lat < BOUND) begin
         @(negedge clk);
         lat++;
         if (err) break;
         if (cipher_en) n++;
      end
      check("timeout_cycles", 256'(n), 256'(TO_CYC));
      check("timeout_err", {255'd0, err}, 256'd1);
      check("timeout_in_ready", {255'd0, in_ready}, 256'd1);
      check("timeout_out_valid", {255'd0, out_valid}, 256'd0);
      stub_mode = 0;

      // Next message still hashes; err stays set. key 2, x 3: E=6, hash 11.
      push_call(254'd3, 254'd2);
      exp_hash_q.push_back(254'd11);
      send(254'd2, 254'd3, 1'b1);
      drain();
      check("err_sticky", {255'd0, err}, 256'd1);

      // Asynchronous reset in the middle of a cipher call.
      push_call(254'd1, 254'd1);
      send(254'd1, 254'd1, 1'b1);
      n = 0;
      while (!cipher_en && n < BOUND) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      check("mid_in_ready", {255'd0, in_ready}, 256'd0);
      check("mid_out_valid", {255'd0, out_valid}, 256'd0);
      check("mid_cipher_rst", {255'd0, cipher_rst}, 256'd1);
      check("mid_cipher_en", {255'd0, cipher_en}, 256'd0);
      check("mid_err", {255'd0, err}, 256'd0);
      check("mid_out_hash", {2'b00, out_hash}, 256'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b1;

      // Post-reset message: key 4, x 6, E=11, hash 21.
      push_call(254'd6, 254'd4);
      exp_hash_q.push_back(254'd21);
      send(254'd4, 254'd6, 1'b1);
      drain();
      check("calls_left", 256'(exp_in_q.size()), 256'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mimc_hash_ctrl.md
Name: mimc_hash_ctrl

Overview:
- Multi-element MiMC7 hash controller in the bn254 hash datapath; sits directly upstream and downstream of mimc_cipher.
- Accepts a valid/ready stream of field elements terminated by a last flag, and sequences one cipher call per element.
- Chains the elements in circomlib multiHash form: r0 = key; r(i+1) = (r(i) + x(i) + E(x(i), r(i))) mod p, where E(x, r) is the cipher output for input x and key r.
- Emits the final r on a valid/ready output. The top level wires the cipher_* ports to a mimc_cipher instance.

Parameters:
- N_BITS, 254, field element width.
- P_MOD, BN254 scalar prime 0x30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001, field modulus.
- TIMEOUT_CYCLES, 4096, maximum cycles to wait for cipher_done before aborting.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  element valid
- in_ready  out  1  controller can accept an element
- in_data  in  N_BITS  field element x
- in_last  in  1  final element of the message
- in_key  in  N_BITS  initial key; sampled only with the first beat of a message
- out_valid  out  1  hash valid
- out_ready  in  1  consumer accepts hash
- out_hash  out  N_BITS  resulting hash
- err  out  1  sticky cipher-timeout flag
- cipher_rst  out  1  active-high restart to the cipher
- cipher_en  out  1  cipher enable
- cipher_in  out  N_BITS  cipher plaintext (x)
- cipher_key  out  N_BITS  cipher key (r)
- cipher_out  in  N_BITS  cipher result
- cipher_done  in  1  cipher result valid

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; first_beat=1; r, x and out_hash are 0; err=0.
  - in_ready=0 while rst is asserted.
  - out_valid=0, cipher_rst=1, cipher_en=0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready:
    - x <= reduce(in_data); reduce subtracts P_MOD once if in_data >= P_MOD, which is sufficient because 2^254 < 2·P_MOD.
    - If first_beat, r <= reduce(in_key).
    - last_q <= in_last; first_beat <= 0.
    - Go to LOAD.
- LOAD (exactly 1 cycle):
  - cipher_rst=1, cipher_en=0, cipher_in=x, cipher_key=r.
  - Next state RUN; the timeout counter clears.
- RUN:
  - cipher_rst=0, cipher_en=1; cipher_in and cipher_key stay stable.
  - Counter increments each cycle.
  - On cipher_done=1: c <= cipher_out, go to ACC. cipher_done is ignored in every other state.
  - If the counter reaches TIMEOUT_CYCLES with no done:
    - err <= 1, first_beat <= 1, go to IDLE; the message is abandoned.
    - The remaining beats of that message are consumed as a new message; the upstream must flush.
- ACC (1 cycle):
  - s = r + x + c, computed in N_BITS+2 bits.
  - Subtract P_MOD up to twice, each time while s >= P_MOD; result is in [0, P_MOD).
  - r <= s.
  - If last_q: out_hash <= s, first_beat <= 1, go to OUT. Otherwise go to IDLE.
- OUT:
  - out_valid=1 and out_hash held stable until out_ready; in_ready=0.
  - On the handshake, go to IDLE.
  - out_valid must not drop without out_ready.
- Per-element latency: 1 (IDLE accept) + 1 (LOAD) + cipher latency + 1 (ACC).
- A message of one element is legal (in_last on the first beat).
- in_key is ignored on non-first beats.
- cipher_rst is 1 in every state except RUN, so the cipher is held idle.
- err clears only on reset.

Decomposition:
- Package mimc_pkg holds:
  - N_BITS default and the P_MOD constant;
  - state enum {IDLE, LOAD, RUN, ACC, OUT};
  - a function mod_reduce_once.
- One sub-module: mimc_mod_add3, the combinational three-operand modular adder used in ACC.

Test Plan (stub cipher returns cipher_out = (in+key+1) mod p, 5 cycles after en rises):
- key=0, single element x=5, last=1:
  - cipher sees in=5, key=0 and returns 6;
  - out_hash = 0+5+6 = 11, out_valid after 1+1+5+1 cycles.
- key=3, elements {1,2}:
  - r1 = 3+1+5 = 9;
  - second call sees in=2, key=9 and returns 12;
  - out_hash = 9+2+12 = 23.
- Wrap-around with x=P_MOD-1, key=P_MOD-1, stub forced to return P_MOD-1 → out_hash = P_MOD-3.
- in_data = P_MOD+4 → cipher_in=4.
- out_ready held low 10 cycles → out_valid and out_hash stable, in_ready=0 throughout; accepted on the first out_ready.
- Stub never asserts done with TIMEOUT_CYCLES=16:
  - err=1 after 16 RUN cycles, state IDLE, in_ready=1;
  - the next message hashes correctly with err still 1.
- Assert rst low mid-RUN → all outputs return to their reset values immediately; the next message after release hashes correctly.
